// File: rtl/sdp_arb_pkg.sv
// rtl/sdp_arb_pkg.sv - shared helpers for sdp port arbiters
package sdp_arb_pkg;

    localparam int MAX_REQ = 32;

    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First valid index searching upward from ptr, modulo n.
    function automatic int rr_grant(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int g;
        int idx;
        g = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (valid[idx[$clog2(MAX_REQ)-1:0]]) g = idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sdp_rr_arb.sv
// rtl/sdp_rr_arb.sv - round-robin grant with registered priority pointer
module sdp_rr_arb
    import sdp_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int TW = tag_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  valid,
    input  logic          adv,
    output logic [TW-1:0] grant,
    output logic          any,
    output logic [TW-1:0] ptr
);

    logic [MAX_REQ-1:0] valid_ext;

    assign valid_ext = MAX_REQ'(valid);
    assign grant     = TW'(rr_grant(valid_ext, int'(ptr), N));
    assign any       = |valid;

    // Pointer only moves on an accepted grant, so a stalled grant is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (grant == TW'(N - 1)) ? '0 : grant + TW'(1);
        end
    end

endmodule

// File: rtl/sdp_rd_arbiter.sv
// rtl/sdp_rd_arbiter.sv - shares one sdp read port among N_REQ requesters
module sdp_rd_arbiter
    import sdp_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W_ADDR    = 16,
    parameter int W_DATA    = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*W_ADDR-1:0]   req_addr,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [W_DATA-1:0]         rsp_data,
    output logic                      mem_addr_valid,
    input  logic                      mem_addr_ready,
    output logic [W_ADDR-1:0]         mem_addr_data,
    input  logic                      mem_data_valid,
    output logic                      mem_data_ready,
    input  logic [W_DATA-1:0]         mem_data_data
);

    localparam int TW = tag_w(N_REQ);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [TW-1:0] grant;
    logic [TW-1:0] rr_ptr;
    logic          any;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          proto_err;
    logic [TW-1:0] head;
    logic [TW-1:0] tag_mem [MAX_OUTST];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    sdp_rr_arb #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .adv   (push),
        .grant (grant),
        .any   (any),
        .ptr   (rr_ptr)
    );

    assign full  = (cnt == CW'(MAX_OUTST));
    assign empty = (cnt == '0);
    assign head  = tag_mem[rd_ptr];

    // Full blocks issue even when a pop is due this cycle.
    assign mem_addr_valid = any & ~full;
    assign mem_addr_data  = req_addr[int'(grant)*W_ADDR +: W_ADDR];
    assign push           = mem_addr_valid & mem_addr_ready;
    assign req_ready      = push ? (N_REQ'(1) << grant) : '0;

    assign mem_data_ready = ~empty & rsp_ready[head];
    assign rsp_valid      = (mem_data_valid & ~empty) ? (N_REQ'(1) << head) : '0;
    assign rsp_data       = mem_data_data;
    assign pop            = mem_data_valid & mem_data_ready;
    assign proto_err      = mem_data_valid & empty;

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    a_no_orphan_data: assert property (@(posedge clk) disable iff (rst) !proto_err)
        else $warning("sdp_rd_arbiter: read data returned with no read outstanding, ignored");

    a_ptr_range: assert property (@(posedge clk) disable iff (rst) int'(rr_ptr) < N_REQ)
        else $error("sdp_rd_arbiter: rr_ptr out of range");

endmodule
